// File: rtl/shared_delay_arbiter.sv
// rtl/shared_delay_arbiter.sv - shared-counter debounce/delay arbiter for N trigger lines
//
// Purpose: queues rising edges of N synchronous request lines and serves them
// one at a time in round-robin order. A single delay counter is shared by all
// channels. After the delay, the served line is re-checked: if it is still high,
// a one-cycle pulse is issued on that channel; otherwise a one-cycle drop is issued.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   req_in     [N_CH] request levels, synchronous to clk
//   pulse_out  [N_CH] one-cycle qualified pulse (one-hot or zero)
//   drop_out   one-cycle pulse when the served request fails qualification
//   busy       high whenever the arbiter is not idle
//   cur_ch     [CH_W] channel being served (holds its value when idle)
//   pend       [N_CH] pending-request vector

module shared_delay_arbiter #(
  parameter int N_CH  = 4,
  parameter int CH_W  = 2,
  parameter int T10MS = 1_249_999,
  parameter int CNT_W = 21
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] req_in,
  output logic [N_CH-1:0] pulse_out,
  output logic            drop_out,
  output logic            busy,
  output logic [CH_W-1:0] cur_ch,
  output logic [N_CH-1:0] pend
);

  typedef enum logic [1:0] {IDLE, COUNT, FIRE, GAP} state_e;

  localparam logic [CNT_W-1:0] T_TERM = CNT_W'(T10MS);

  state_e            state_q;
  logic [N_CH-1:0]   req_q;
  logic [N_CH-1:0]   pend_q, pend_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CH_W-1:0]   cur_q;
  logic [CH_W-1:0]   last_q;
  logic [N_CH-1:0]   pulse_q;
  logic              drop_q;

  logic [N_CH-1:0]   rise;
  logic [N_CH-1:0]   clr;
  logic              gnt_found;
  logic [CH_W-1:0]   gnt_idx;
  logic [CH_W-1:0]   cand;

  assign rise = req_in & ~req_q;

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N_CH; k++) begin
      cand = CH_W'((int'(last_q) + k) % N_CH);
      if (!gnt_found && pend_q[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // A rise in the same cycle as the grant re-queues the channel (set wins).
  always_comb begin
    clr = '0;
    if (state_q == IDLE && gnt_found) begin
      clr = N_CH'(1) << gnt_idx;
    end
    pend_d = (pend_q & ~clr) | rise;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      pend_q  <= '0;
      cnt_q   <= '0;
      cur_q   <= '0;
      last_q  <= CH_W'(N_CH - 1);
      pulse_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      req_q  <= req_in;
      pend_q <= pend_d;
      case (state_q)
        IDLE: begin
          if (gnt_found) begin
            cur_q   <= gnt_idx;
            last_q  <= gnt_idx;
            cnt_q   <= '0;
            state_q <= COUNT;
          end
        end
        COUNT: begin
          if (cnt_q == T_TERM) begin
            cnt_q   <= '0;
            state_q <= FIRE;
            // Qualification: the line must still be high after the delay.
            if (req_in[cur_q]) begin
              pulse_q <= N_CH'(1) << cur_q;
            end else begin
              drop_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        FIRE: begin
          pulse_q <= '0;
          drop_q  <= 1'b0;
          state_q <= GAP;
        end
        GAP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign pulse_out = pulse_q;
  assign drop_out  = drop_q;
  assign busy      = (state_q != IDLE);
  assign cur_ch    = cur_q;
  assign pend      = pend_q;

endmodule

// File: tb/tb_shared_delay_arbiter.sv
// tb/tb_shared_delay_arbiter.sv - self-checking bench for shared_delay_arbiter

module tb_shared_delay_arbiter;

  localparam int T = 9;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_in;
  logic [3:0] pulse_out;
  logic       drop_out;
  logic       busy;
  logic [1:0] cur_ch;
  logic [3:0] pend;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: timestamps instead of a counter.
  int         t;
  bit         m_act;
  int         m_g;
  int         m_cur;
  int         m_last;
  logic [3:0] m_pend;
  logic [3:0] m_prev;
  logic [3:0] e_pulse;
  bit         e_drop;

  shared_delay_arbiter #(
    .N_CH(4), .CH_W(2), .T10MS(T), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .pulse_out(pulse_out),
    .drop_out(drop_out), .busy(busy), .cur_ch(cur_ch), .pend(pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic model_reset();
    t = 0; m_act = 0; m_g = 0; m_cur = 0; m_last = N - 1;
    m_pend = '0; m_prev = '0; e_pulse = '0; e_drop = 0;
  endtask

  task automatic model_step();
    logic [3:0] rise;
    logic [3:0] clr;
    int c;
    rise = req_in & ~m_prev;
    m_prev = req_in;
    clr = '0;
    e_pulse = '0;
    e_drop = 0;
    if (!m_act) begin
      if (m_pend != 0) begin
        for (int k = 1; k <= N; k++) begin
          c = (m_last + k) % N;
          if (m_pend[c]) begin
            m_cur = c;
            break;
          end
        end
        m_last = m_cur;
        m_act = 1;
        m_g = t;
        clr[m_cur] = 1'b1;
      end
    end else if (t == m_g + T + 1) begin
      if (req_in[m_cur]) e_pulse[m_cur] = 1'b1;
      else e_drop = 1;
    end else if (t == m_g + T + 3) begin
      m_act = 0;
    end
    m_pend = (m_pend & ~clr) | rise;
    t++;
  endtask

  task automatic compare_all();
    chk("pulse", 32'(pulse_out), 32'(e_pulse));
    chk("drop", 32'(drop_out), 32'(e_drop));
    chk("busy", 32'(busy), 32'(m_act));
    chk("cur_ch", 32'(cur_ch), 32'(m_cur));
    chk("pend", 32'(pend), 32'(m_pend));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  int pulse_at;
  int p3_seen;

  initial begin
    rst = 1'b0;
    req_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst = 1'b1;

    // Single request on channel 2, held; pulse visible after the 12th edge.
    repeat (3) cycle();
    req_in = 4'b0100;
    pulse_at = 0;
    for (int n = 1; n <= 20; n++) begin
      cycle();
      if (pulse_out != 0 && pulse_at == 0) pulse_at = n;
    end
    chk("latency", 32'(pulse_at), 32'd12);
    req_in = '0;
    repeat (5) cycle();

    // Bounce: high for 3 cycles then low, expect a drop.
    req_in = 4'b0010;
    repeat (3) cycle();
    req_in = '0;
    repeat (15) cycle();

    // All four together, held: round-robin service.
    req_in = 4'b1111;
    repeat (60) cycle();
    req_in = 4'b1110;
    repeat (2) cycle();
    req_in = 4'b1111;
    repeat (20) cycle();
    req_in = '0;
    repeat (5) cycle();

    // Starvation: channel 0 toggles continuously while channel 3 is held.
    req_in = 4'b1000;
    p3_seen = 0;
    for (int n = 0; n < 4 * (T + 4) + 2; n++) begin
      cycle();
      if (pulse_out[3]) p3_seen = 1;
      req_in[0] = ~req_in[0];
    end
    chk("starve_ch3", 32'(p3_seen), 32'd1);
    req_in = '0;
    repeat (20) cycle();

    // Random toggling.
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 9) == 0) req_in[b] = ~req_in[b];
      end
      cycle();
    end

    // Reset mid-COUNT with pend=0110, then a line held high at release.
    do_reset();
    req_in = 4'b0111;
    repeat (7) cycle();
    chk("pre_rst_pend", 32'(pend), 32'h6);
    rst = 1'b0;
    #1;
    model_reset();
    chk("rst_pulse", 32'(pulse_out), 32'd0);
    chk("rst_drop", 32'(drop_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cur", 32'(cur_ch), 32'd0);
    chk("rst_pend", 32'(pend), 32'd0);
    @(negedge clk);
    req_in = 4'b0010;
    rst = 1'b1;
    pulse_at = 0;
    for (int n = 1; n <= 20; n++) begin
      cycle();
      if (pulse_out[1] && pulse_at == 0) pulse_at = n;
    end
    chk("rst_latency", 32'(pulse_at), 32'd12);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
